coef_normalizer: RTL
====================

# coef_normalizer

Sequential back-end for the modular multiplier. It accepts one product in redundant coefficient form: NUM_ELEMENTS coefficients of BIT_LEN bits, radix 2^WORD_LEN, where each coefficient may carry overflow bits above WORD_LEN. It propagates carries word-serially to produce a canonical binary value, then performs repeated word-serial conditional subtraction of the modulus until the result is below P. It sits between the multiplier's registered output and any consumer that needs a fully reduced, non-redundant operand, such as the ladder controller or the output serializer.

## Interface
- NUM_ELEMENTS, 17, number of coefficients/words
- BIT_LEN, 17, input coefficient width
- WORD_LEN, 16, radix width of one output word
- MAX_SUB_PASSES, 4, maximum number of successful modulus subtractions before error
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input product valid
- in_ready  out  1  block can accept; high only in IDLE
- in_coef  in  BIT_LEN x NUM_ELEMENTS  redundant coefficients, index 0 least significant
- mod_p  in  WORD_LEN x NUM_ELEMENTS  modulus words, sampled with in_coef
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- out_word  out  WORD_LEN x NUM_ELEMENTS  canonical reduced result
- out_err  out  1  error flag qualified by out_valid

## Operation
- States: IDLE, PROP, SUB, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_coef and mod_p, clear word index k, carry, pass count and error; go to PROP.
- PROP, one word per cycle, k=0..NUM_ELEMENTS-1:
  - s = in_coef[k] + carry, with 2 carry bits and s of WORD_LEN+2 bits.
  - r[k] = s[WORD_LEN-1:0]; carry = s>>WORD_LEN.
  - After k=NUM_ELEMENTS-1, a nonzero carry sets the err flag (value ≥ 2^(WORD_LEN·NUM_ELEMENTS)). The carry is discarded and the block moves to SUB with k=0, borrow=0.
- SUB pass, one word per cycle:
  - d[k] = r[k] − p[k] − borrow, mod 2^WORD_LEN, written to a scratch register.
  - borrow = 1 on underflow.
- End of pass, final borrow=1 (r < P): r unchanged; go to DONE.
- End of pass, final borrow=0 (r ≥ P): r := d and pass count increments.
  - If pass count reaches MAX_SUB_PASSES, set err and go to DONE.
  - Otherwise start another SUB pass.
- DONE: out_valid=1; out_word=r; out_err=err. On out_ready, go to IDLE.
- Output arithmetic is unsigned. out_word is always < 2^WORD_LEN per word. out_word < P whenever out_err=0 and P ≠ 0.
- P = 0: every pass succeeds, so the block exits on pass limit with err=1.

## Timing
- Reset values: in_ready=0 during reset and 1 the cycle after; out_valid=0; out_word=0; out_err=0; state=IDLE.
- Accept at cycle T. PROP occupies T+1..T+N, where N=NUM_ELEMENTS.
- Each SUB pass takes N cycles. With n successful passes and a terminating failing pass, out_valid first rises at T+1+N·(n+2).
  - For N=17: 35 cycles for n=0, 52 for n=1.
- Pass-limit exit: out_valid rises at T+1+N·(1+MAX_SUB_PASSES).
- out_valid and out_word are stable while out_ready=0. On the handshake cycle the state returns to IDLE, so in_ready=1 the next cycle. There is no input/output overlap.
- in_valid outside IDLE is ignored; the input is not consumed.
- rst mid-operation: the next cycle is IDLE, the partial result is discarded, and outputs return to their reset values.

## Structure
- Shared package modmul_pkg holds:
  - NUM_ELEMENTS, WORD_LEN and BIT_LEN defaults.
  - The state enum type (IDLE/PROP/SUB/DONE).
  - The typedefs for the coefficient vector and the word vector.
- One sub-module, word_addsub_slice, is natural: a single-word adder/subtractor with carry/borrow in and out.
  - Its mode input selects add (PROP) or subtract (SUB).
  - It is instantiated once and time-multiplexed by the word index.

## Test plan
- All in_coef=0, P=2^255−19 → out_word all 0, out_err=0, out_valid at T+35.
- in_coef[0]=0x1FFFF, others 0, same P → out_word[0]=0xFFFF, out_word[1]=0x0001, rest 0, latency 35.
- in_coef equal to P's words exactly → one successful pass, out_word all 0, out_err=0, latency 52.
- Value 3·P with MAX_SUB_PASSES=2 → out_word = P, out_err=1, latency 52.
- in_coef[16]=0x10000, others 0 → out_err=1 (carry beyond 272 bits); out_valid still rises.
- Backpressure, then reset:
  - Hold out_ready=0 for 10 cycles after out_valid → data and out_err are stable and in_ready=0. Handshake follows, and in_ready=1 next cycle.
  - Assert rst at PROP k=5 → in_ready=1 and out_valid=0 the next cycle. A following product completes correctly.

Source files
------------

// File: rtl/modmul_pkg.sv
// Shared definitions for the modular multiplier back-end: default sizes,
// controller state encoding and the coefficient / word vector types.
package modmul_pkg;
    localparam int NUM_ELEMENTS = 17;
    localparam int WORD_LEN     = 16;
    localparam int BIT_LEN      = 17;

    typedef enum logic [1:0] {IDLE, PROP, SUB, DONE} state_e;

    typedef logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]  coef_vec_t;
    typedef logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0] word_vec_t;
endpackage

// File: rtl/word_addsub_slice.sv
// Single-word datapath: adds a redundant coefficient plus a 2-bit carry, or
// subtracts a modulus word plus borrow from a canonical word.
module word_addsub_slice #(
    parameter int WORD_LEN = 16,
    parameter int BIT_LEN  = 17
) (
    input  logic                sub_i,
    input  logic [BIT_LEN-1:0]  a_i,
    input  logic [WORD_LEN-1:0] b_i,
    input  logic [1:0]          cin_i,
    output logic [WORD_LEN-1:0] res_o,
    output logic [1:0]          cout_o
);
    localparam int SW = WORD_LEN + 2;
    localparam int DW = WORD_LEN + 1;

    logic [SW-1:0] sum;
    logic [DW-1:0] diff;

    always_comb begin
        sum  = SW'(a_i) + SW'(cin_i);
        // Top bit of the one-bit-wider difference is the borrow out.
        diff = DW'(a_i[WORD_LEN-1:0]) - DW'(b_i) - DW'(cin_i[0]);
        if (sub_i) begin
            res_o  = diff[WORD_LEN-1:0];
            cout_o = {1'b0, diff[DW-1]};
        end else begin
            res_o  = sum[WORD_LEN-1:0];
            cout_o = sum[SW-1:WORD_LEN];
        end
    end
endmodule

// File: rtl/coef_normalizer.sv
// Word-serial carry propagation of a redundant product followed by repeated
// conditional subtraction of the modulus until the value drops below P.
module coef_normalizer
    import modmul_pkg::*;
#(
    parameter int NUM_ELEMENTS   = modmul_pkg::NUM_ELEMENTS,
    parameter int BIT_LEN        = modmul_pkg::BIT_LEN,
    parameter int WORD_LEN       = modmul_pkg::WORD_LEN,
    parameter int MAX_SUB_PASSES = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]    in_coef,
    input  logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0]   mod_p,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0]   out_word,
    output logic                                    out_err
);
    localparam int KW = $clog2(NUM_ELEMENTS);
    localparam int PW = $clog2(MAX_SUB_PASSES + 1);

    state_e                                 state_q, state_d;
    logic [KW-1:0]                          k_q, k_d;
    logic [1:0]                             carry_q, carry_d;
    logic [PW-1:0]                          pass_q, pass_d;
    logic                                   err_q, err_d;
    logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   coef_q, coef_d;
    logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0]  p_q, p_d;
    logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0]  r_q, r_d;
    logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0]  d_q, d_d;

    logic [BIT_LEN-1:0]  slice_a;
    logic [WORD_LEN-1:0] slice_res;
    logic [1:0]          slice_cout;
    logic                k_last;
    logic [PW-1:0]       pass_inc;
    logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0] d_full;

    assign slice_a = (state_q == PROP) ? coef_q[k_q] : BIT_LEN'(r_q[k_q]);

    word_addsub_slice #(.WORD_LEN(WORD_LEN), .BIT_LEN(BIT_LEN)) u_slice (
        .sub_i  (state_q == SUB),
        .a_i    (slice_a),
        .b_i    (p_q[k_q]),
        .cin_i  (carry_q),
        .res_o  (slice_res),
        .cout_o (slice_cout)
    );

    assign k_last   = (k_q == KW'(NUM_ELEMENTS - 1));
    assign pass_inc = pass_q + PW'(1);

    always_comb begin
        // Scratch including the word being produced this cycle.
        d_full      = d_q;
        d_full[k_q] = slice_res;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        pass_d  = pass_q;
        err_d   = err_q;
        coef_d  = coef_q;
        p_d     = p_q;
        r_d     = r_q;
        d_d     = d_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    coef_d  = in_coef;
                    p_d     = mod_p;
                    k_d     = '0;
                    carry_d = '0;
                    pass_d  = '0;
                    err_d   = 1'b0;
                    state_d = PROP;
                end
            end
            PROP: begin
                r_d[k_q] = slice_res;
                carry_d  = slice_cout;
                k_d      = k_q + KW'(1);
                if (k_last) begin
                    // Carry out of the top word means the value does not fit.
                    err_d   = err_q | (|slice_cout);
                    carry_d = '0;
                    k_d     = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                d_d[k_q] = slice_res;
                carry_d  = slice_cout;
                k_d      = k_q + KW'(1);
                if (k_last) begin
                    carry_d = '0;
                    k_d     = '0;
                    if (slice_cout[0]) begin
                        state_d = DONE;
                    end else begin
                        r_d    = d_full;
                        pass_d = pass_inc;
                        if (pass_inc == PW'(MAX_SUB_PASSES)) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= '0;
            pass_q  <= '0;
            err_q   <= 1'b0;
            coef_q  <= '0;
            p_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            coef_q  <= coef_d;
            p_q     <= p_d;
            r_q     <= r_d;
            d_q     <= d_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_word  = r_q;
    assign out_err   = err_q;
endmodule
